// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry buffer with operand forwarding and hazard stall.
// Define ID_EX_FORWARDING_EN for forwarding (load-use stalls only); otherwise every RAW hazard stalls.
module id_ex_stage #(
  parameter int N    = 32,
  parameter int ADDR = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [ADDR-1:0] rs1_i,
  input  logic [ADDR-1:0] rs2_i,
  input  logic [ADDR-1:0] rd_i,
  input  logic [N-1:0]    rd1_i,
  input  logic [N-1:0]    rd2_i,
  input  logic [N-1:0]    imm_i,
  input  logic [7:0]      ctrl_i,
  input  logic [ADDR-1:0] mem_rd_i,
  input  logic            mem_reg_write_i,
  input  logic [N-1:0]    mem_data_i,
  input  logic [ADDR-1:0] wb_rd_i,
  input  logic            wb_reg_write_i,
  input  logic [N-1:0]    wb_data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [N-1:0]    op1_o,
  output logic [N-1:0]    op2_o,
  output logic [N-1:0]    imm_o,
  output logic [ADDR-1:0] rd_o,
  output logic [7:0]      ctrl_o,
  output logic            stall_o,
  output logic [15:0]     stall_cnt_o
);

  logic            r_out_valid;
  logic [N-1:0]    r_op1, r_op2, r_imm;
  logic [ADDR-1:0] r_rd;
  logic [7:0]      r_ctrl;
  logic [15:0]     r_stall_cnt;

  logic            w_out_free, w_load_use, w_stall, w_accept;
  logic [N-1:0]    w_op1, w_op2;

`ifdef ID_EX_FORWARDING_EN
  // Newest producer wins: EX/MEM result shadows the write-back result.
  function automatic logic [N-1:0] f_operand(input logic [ADDR-1:0] rs, input logic [N-1:0] rf_data);
    if (rs == '0)
      return '0;
    else if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs))
      return mem_data_i;
    else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs))
      return wb_data_i;
    else
      return rf_data;
  endfunction
`else
  function automatic logic [N-1:0] f_operand(input logic [ADDR-1:0] rs, input logic [N-1:0] rf_data);
    return (rs == '0) ? '0 : rf_data;
  endfunction

  // Any in-flight writer of a nonzero source register is a hazard without forwarding.
  function automatic logic f_raw(input logic [ADDR-1:0] rs);
    return (rs != '0) &&
           ((r_out_valid && r_ctrl[0] && (r_rd == rs)) ||
            (mem_reg_write_i && (mem_rd_i == rs)) ||
            (wb_reg_write_i && (wb_rd_i == rs)));
  endfunction

  logic w_unused;
  assign w_unused = ^{mem_data_i, wb_data_i};
`endif

  assign w_out_free = ~r_out_valid | out_ready_i;
  assign w_load_use = in_valid_i & r_out_valid & r_ctrl[1] & (r_rd != '0) &
                      ((r_rd == rs1_i) | (r_rd == rs2_i));

`ifdef ID_EX_FORWARDING_EN
  assign w_stall = w_load_use;
`else
  assign w_stall = w_load_use | (in_valid_i & (f_raw(rs1_i) | f_raw(rs2_i)));
`endif

  assign in_ready_o = flush_i | (w_out_free & ~w_stall);
  assign w_accept   = in_valid_i & in_ready_o & ~flush_i;
  assign w_op1      = f_operand(rs1_i, rd1_i);
  assign w_op2      = f_operand(rs2_i, rd2_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_ctrl      <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (flush_i) begin
        r_out_valid <= 1'b0;
      end else if (w_out_free) begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_op1  <= w_op1;
          r_op2  <= w_op2;
          r_imm  <= imm_i;
          r_rd   <= rd_i;
          r_ctrl <= ctrl_i;
        end
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign out_valid_o = r_out_valid;
  assign op1_o       = r_op1;
  assign op2_o       = r_op2;
  assign imm_o       = r_imm;
  assign rd_o        = r_rd;
  assign ctrl_o      = r_ctrl;
  assign stall_o     = w_stall;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter N, default 32: data word width.
REQ-002 SHALL have parameter ADDR, default 5: register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid_i input 1 and in_ready_o output 1: decode-side handshake.
REQ-006 SHALL have ports rs1_i, rs2_i, rd_i  input  ADDR each: source and destination register addresses.
REQ-007 SHALL have ports rd1_i, rd2_i  input  N each: register-file read data for rs1/rs2.
REQ-008 SHALL have ports imm_i input N and ctrl_i input 8: immediate and control; ctrl bit0 = reg_write, bit1 = mem_read.
REQ-009 SHALL have ports mem_rd_i input ADDR, mem_reg_write_i input 1, mem_data_i input N: EX/MEM-stage result.
REQ-010 SHALL have ports wb_rd_i input ADDR, wb_reg_write_i input 1, wb_data_i input N: write-back stage result.
REQ-011 SHALL have port flush_i  input  1: discard held and incoming instruction.
REQ-012 SHALL have ports out_valid_o output 1 and out_ready_i input 1: execute-side handshake.
REQ-013 SHALL have outputs op1_o, op2_o, imm_o (N each), rd_o (ADDR), ctrl_o (8): registered operands and control.
REQ-014 SHALL have outputs stall_o (1) and stall_cnt_o (16): hazard stall flag and stall-cycle counter.

Function
REQ-015 SHALL set out_free = ~out_valid_o | out_ready_i.
REQ-016 SHALL drive in_ready_o = out_free & ~stall_o, or 1 when flush_i = 1.
REQ-017 SHALL assert stall_o combinationally when all hold: in_valid_i, out_valid_o, ctrl_o[1], rd_o != 0, and rd_o equals rs1_i or rs2_i (load-use).
REQ-018 SHALL, on an edge with out_free = 1, load the input bundle and set out_valid_o = 1 when in_valid_i & in_ready_o & ~flush_i; otherwise SHALL clear out_valid_o.
REQ-019 SHALL hold every output register unchanged while out_free = 0 and flush_i = 0.
REQ-020 SHALL clear out_valid_o on any edge with flush_i = 1, regardless of out_ready_i or in_valid_i; the incoming instruction is dropped.
REQ-021 SHALL compute each captured operand with this priority: source address 0 -> 0; match on mem_rd_i with mem_reg_write_i = 1 and mem_rd_i != 0 -> mem_data_i; match on wb_rd_i with wb_reg_write_i = 1 and wb_rd_i != 0 -> wb_data_i; else rdX_i.
REQ-022 SHALL pass imm_i, rd_i and ctrl_i unmodified into the output registers.
REQ-023 SHALL increment stall_cnt_o on each edge where stall_o = 1, saturating at 16'hFFFF.
REQ-024 SHALL keep a single-entry buffer; latency from in accept to out_valid_o = 1 is one cycle.

Reset
REQ-025 SHALL, when reset = 0, asynchronously clear out_valid_o, op1_o, op2_o, imm_o, rd_o, ctrl_o and stall_cnt_o to 0.
REQ-026 SHALL, on reset mid-transfer, lose the held instruction; in_ready_o becomes 1 after reset deasserts.

Configuration
REQ-027 SHALL, with macro ID_EX_FORWARDING_EN defined, apply REQ-021 forwarding and the load-use-only stall of REQ-017.
REQ-028 SHALL, without ID_EX_FORWARDING_EN, capture rdX_i directly (x0 still forced to 0). In this mode stall_o SHALL also assert on any nonzero rs1_i/rs2_i match against a valid reg-writing rd_o, mem_rd_i or wb_rd_i.

Verification
REQ-029 SHALL cover reset: hold reset = 0 with in_valid_i = 1 -> out_valid_o = 0, stall_cnt_o = 0, in_ready_o = 1 after release.
REQ-030 SHALL cover MEM forwarding: mem_rd_i = 5, mem_data_i = 0xAAAA0000, mem_reg_write_i = 1, rs1_i = 5, rd1_i = 0x1 -> next cycle op1_o = 0xAAAA0000.
REQ-031 SHALL cover priority and x0: mem and wb both target rs2_i = 7 (0x11 vs 0x22) -> op2_o = 0x11; rs1_i = 0 with mem_rd_i = 0 -> op1_o = 0.
REQ-032 SHALL cover load-use: held load with rd_o = 3, next input rs2_i = 3 -> stall_o = 1 for one cycle, bubble out, stall_cnt_o = 1, then accepted.
REQ-033 SHALL cover backpressure and flush: out_ready_i = 0 for 3 cycles -> outputs stable, in_ready_o = 0; flush_i = 1 with in_valid_i = 1 -> out_valid_o = 0 next cycle.
